cfg_chain_driver: RTL and testbench

Master-side driver for the serial configuration chain. It accepts parallel configuration words over a valid/ready handshake and shifts each word MSB-first onto the chain as a `data_in` / `data_clk` pair. The chain is formed by the synapse, dendrite and neuron `config_if` slave ports. The block sits between the host/test register interface and each `cfg_in` entry point of the network array, one instance per chain. An optional readback path samples the chain tail so a full-chain load can be verified.

---
 rtl/cfg_chain_driver.sv | 143 ++++++++++++++
 tb/tb_cfg_chain_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_driver
// Brief    : Shifts parallel config words MSB-first onto a serial config chain
//            as a data_in/data_clk pair; optional tail readback is enabled by
//            the macro CFG_CHAIN_READBACK_EN.
// Revision : 1.0
// ============================================================================
module cfg_chain_driver #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_ready,
    output logic                  cfg_data_clk,
    output logic                  cfg_data_in,
    input  logic                  cfg_data_ret,
    output logic                  busy,
    output logic                  rdata_valid,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_LOW      = 2'd1;
    localparam logic [1:0]       c_HIGH     = 2'd2;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(WORD_WIDTH - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DIV_W-1:0]      r_div_cnt;
    logic                  w_div_done;
    logic                  w_accept;
    logic                  w_last_bit;

    assign w_div_done = (r_div_cnt == c_DIV_LAST);
    assign w_accept   = word_valid && (r_state == c_IDLE);
    assign w_last_bit = (r_bit_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (w_accept)   w_state_next = c_LOW;
            c_LOW:  if (w_div_done) w_state_next = c_HIGH;
            c_HIGH: if (w_div_done) w_state_next = w_last_bit ? c_IDLE : c_LOW;
            default:                w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        word_ready   = (r_state == c_IDLE);
        busy         = (r_state != c_IDLE);
        cfg_data_clk = (r_state == c_HIGH);
        cfg_data_in  = (r_state != c_IDLE) && r_shift[WORD_WIDTH-1];
    end

    // The shift register only advances when leaving HIGH, so data_in stays
    // stable for a full divider period on both sides of the data_clk rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= word_data;
                        r_bit_cnt <= c_BIT_LAST;
                        r_div_cnt <= '0;
                    end
                end
                c_LOW: begin
                    r_div_cnt <= w_div_done ? '0 : r_div_cnt + DIV_W'(1);
                end
                c_HIGH: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        if (!w_last_bit) begin
                            r_shift   <= r_shift << 1;
                            r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_div_cnt <= '0;
                end
            endcase
        end
    end

`ifdef CFG_CHAIN_READBACK_EN
    logic [WORD_WIDTH-1:0] r_rb_shift;
    logic                  w_clk_rise;
    logic                  w_word_done;

    assign w_clk_rise  = (r_state == c_LOW) && w_div_done;
    assign w_word_done = (r_state == c_HIGH) && w_div_done && w_last_bit;

    // The tail is sampled on the system edge that raises data_clk, i.e. just
    // before the chain shifts, so each sample is the bit leaving the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rb_shift  <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= w_word_done;
            if (w_clk_rise) begin
                r_rb_shift <= (r_rb_shift << 1) | WORD_WIDTH'(cfg_data_ret);
            end
            if (w_word_done) begin
                rdata <= r_rb_shift;
            end
        end
    end
`else
    logic w_unused_ret;
    assign w_unused_ret = cfg_data_ret;
    assign rdata        = '0;
    assign rdata_valid  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_driver.sv
`default_nettype none
// Bench for cfg_chain_driver: two instances (CLK_DIV=1 and 3) feeding chain
// models; a scoreboard compares every completed word against the queue.
module tb_cfg_chain_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_ready, a_dclk, a_din, a_busy, a_rv;
    logic        b_ready, b_dclk, b_din, b_busy, b_rv;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] chain_a = '0, chain_b = '0;
    logic        a_ret, b_ret;

    assign a_ret = chain_a[15];
    assign b_ret = chain_b[15];

    cfg_chain_driver #(.WORD_WIDTH(16), .CLK_DIV(1)) u_dut_a (
        .clk(clk), .reset(rst_n), .word_valid(a_valid), .word_data(a_data),
        .word_ready(a_ready), .cfg_data_clk(a_dclk), .cfg_data_in(a_din),
        .cfg_data_ret(a_ret), .busy(a_busy), .rdata_valid(a_rv), .rdata(a_rdata)
    );

    cfg_chain_driver #(.WORD_WIDTH(16), .CLK_DIV(3)) u_dut_b (
        .clk(clk), .reset(rst_n), .word_valid(b_valid), .word_data(b_data),
        .word_ready(b_ready), .cfg_data_clk(b_dclk), .cfg_data_in(b_din),
        .cfg_data_ret(b_ret), .busy(b_busy), .rdata_valid(b_rv), .rdata(b_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tot_a    = 0;
    int tot_b    = 0;
    int rv_cnt   = 0;
    logic [15:0] rv_last = '0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Chain models: each stage captures data_in on the rising data_clk.
    always @(posedge a_dclk) begin
        chain_a <= {chain_a[14:0], a_din};
        tot_a   <= tot_a + 1;
    end
    always @(posedge b_dclk) begin
        chain_b <= {chain_b[14:0], b_din};
        tot_b   <= tot_b + 1;
    end

    // Scoreboard monitor: a word is complete when busy falls outside reset.
    int   last_a = 0, last_b = 0;
    logic pb_a = 1'b0, pb_b = 1'b0, prev_rv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = tot_a;
            last_b = tot_b;
            pb_a = 1'b0;
            pb_b = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (pb_a && !a_busy) begin
                if (q_a.size() == 0) check("a_unexpected_word", 1, 0);
                else check("a_word", chain_a, q_a.pop_front());
                check("a_bits", tot_a - last_a, 16);
                last_a = tot_a;
            end
            if (pb_b && !b_busy) begin
                if (q_b.size() == 0) check("b_unexpected_word", 1, 0);
                else check("b_word", chain_b, q_b.pop_front());
                check("b_bits", tot_b - last_b, 16);
                last_b = tot_b;
            end
            if (a_rv) begin
                check("a_rv_single_cycle", prev_rv, 0);
                rv_cnt++;
                rv_last = a_rdata;
            end
            pb_a = a_busy;
            pb_b = b_busy;
            prev_rv = a_rv;
        end
    end

    task automatic send_a(input logic [15:0] w, input bit hold, input bit push, output int acc);
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = w;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) q_a.push_back(w);
        if (!hold) a_valid = 1'b0;
    endtask

    // Cycle numbers are relative to the accept edge (cycle 0).
    task automatic measure_a(input int acc, output int first_rise, output int last_rise,
                             output int n_rise, output int ready_rel);
        logic prev = 1'b0;
        int   rel;
        first_rise = -1;
        last_rise  = -1;
        n_rise     = 0;
        ready_rel  = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rel = cyc - acc + 1;
            if (a_dclk && !prev) begin
                if (n_rise == 0) first_rise = rel;
                last_rise = rel;
                n_rise++;
            end
            prev = a_dclk;
            if (a_ready) begin
                ready_rel = rel;
                break;
            end
        end
        if (ready_rel < 0) check("a_ready_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, fr, lr, nr, rr, rel, base, t0;
        int busy_cnt, din_cnt, din_last, hi_cnt, rises, first;
        logic prev;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_dclk", a_dclk, 0);
        check("rst_din", a_din, 0);
        check("rst_rv", a_rv, 0);
        check("rst_rdata", a_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single word 0xA5C3
        send_a(16'hA5C3, 1'b0, 1'b1, acc);
        @(negedge clk);
        check("t1_busy_c1", a_busy, 1);
        check("t1_din_c1", a_din, 1);
        measure_a(acc, fr, lr, nr, rr);
        check("t1_first_rise", fr, 2);
        check("t1_last_rise", lr, 32);
        check("t1_rises", nr, 16);
        check("t1_ready_cycle", rr, 33);

        // Back-to-back 0x0001 then 0xFFFF with valid held
        send_a(16'h0001, 1'b1, 1'b1, acc);
        a_data = 16'hFFFF;
        q_a.push_back(16'hFFFF);
        measure_a(acc, fr, lr, nr, rr);
        check("t2_ready_cycle", rr, 33);
        @(posedge clk);
        #1;
        acc2 = cyc;
        a_valid = 1'b0;
        check("t2_second_accept", acc2 - acc, 33);
        measure_a(acc2, fr, lr, nr, rr);
        check("t2_rises", nr, 16);

        // Divider CLK_DIV=3, word 0x8000
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 16'h8000;
        @(posedge clk);
        #1;
        acc = cyc;
        q_b.push_back(16'h8000);
        b_valid = 1'b0;
        busy_cnt = 0; din_cnt = 0; din_last = -1; hi_cnt = 0; rises = 0; first = -1;
        prev = 1'b0;
        rr = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rel = cyc - acc + 1;
            if (b_ready) begin
                rr = rel;
                break;
            end
            if (b_busy) busy_cnt++;
            if (b_din) begin
                din_cnt++;
                din_last = rel;
            end
            if (b_dclk) begin
                hi_cnt++;
                if (!prev) begin
                    rises++;
                    if (first < 0) first = rel;
                end
            end
            prev = b_dclk;
        end
        check("t3_busy_cycles", busy_cnt, 96);
        check("t3_din_high_cycles", din_cnt, 6);
        check("t3_din_last_cycle", din_last, 6);
        check("t3_dclk_high_cycles", hi_cnt, 48);
        check("t3_rises", rises, 16);
        check("t3_first_rise", first, 4);
        check("t3_ready_cycle", rr, 97);

        // Readback: 0x1234 then 0xBEEF through the looped chain model
        base = rv_cnt;
        send_a(16'h1234, 1'b0, 1'b1, acc);
        measure_a(acc, fr, lr, nr, rr);
        send_a(16'hBEEF, 1'b0, 1'b1, acc);
        measure_a(acc, fr, lr, nr, rr);
        repeat (2) @(negedge clk);
`ifdef CFG_CHAIN_READBACK_EN
        check("rb_pulses", rv_cnt - base, 2);
        check("rb_rdata", rv_last, 16'h1234);
`else
        check("rb_pulses", rv_cnt, 0);
        check("rb_rdata_zero", a_rdata, 0);
`endif

        // Abort during bit 5 (LOW phase, cycle 11) of 0xFFFF
        t0 = tot_a;
        send_a(16'hFFFF, 1'b0, 1'b0, acc);
        for (int i = 0; i < 50 && (cyc - acc + 1) < 11; i++) @(negedge clk);
        check("ab_din_before", a_din, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ab_dclk", a_dclk, 0);
        check("ab_din", a_din, 0);
        check("ab_ready", a_ready, 1);
        check("ab_busy", a_busy, 0);
        check("ab_bits_shifted", tot_a - t0, 5);
        check("ab_chain_low_bits", chain_a[4:0], 5'h1F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send_a(16'h3C5A, 1'b0, 1'b1, acc);
        measure_a(acc, fr, lr, nr, rr);
        check("ab_fresh_rises", nr, 16);
        check("ab_fresh_ready", rr, 33);

        repeat (5) @(negedge clk);
        check("q_a_empty", q_a.size(), 0);
        check("q_b_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
